adsr_envelope_ctrl: RTL and testbench
=====================================

# adsr_envelope_ctrl

Envelope sequencer that turns the keyboard gate (`note_in`) and the user-edited amplitude/ADSR settings into a time-varying envelope level for the synth voice. It sits between the IO/parameter registers and the ALU/wave datapath. Each `tick` strobe advances the level through attack, decay, sustain and release. The output `env` scales the oscillator in place of the raw static `amplitude`.

## Interface
Parameters:
- `WIDTH`, default 31: width of the level, amplitude and ADSR operands.

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `tick`  in  1  envelope-rate enable strobe; the level moves only on cycles where `tick`=1.
- `note_in`  in  1  key gate; 1 while a key is held.
- `amplitude`  in  WIDTH  peak level reached by attack.
- `attack`  in  WIDTH  attack increment per tick; 0 means instantaneous.
- `decay`  in  WIDTH  decay decrement per tick; 0 means instantaneous.
- `sustain`  in  WIDTH  sustain level; clamped to `amplitude`.
- `rel`  in  WIDTH  release decrement per tick; 0 means instantaneous.
- `env`  out  WIDTH  current envelope level (registered).
- `state`  out  3  current phase: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.
- `active`  out  1  1 whenever `state`≠IDLE.
- `done`  out  1  one-cycle pulse when release reaches 0.

## Operation
- Sustain level: `sus_lvl` = min(`sustain`, `amplitude`). It is re-evaluated every cycle, so live parameter edits take effect immediately.
- Gate: `note_in` is registered into `gate_q`. Rise = `note_in`&!`gate_q`. Fall = !`note_in`&`gate_q`.
- Gate events are evaluated every clk, independent of `tick`:
  - Rise in any state → ATTACK. `env` is kept, so retrigger starts from the current level.
  - `note_in`=0 in ATTACK, DECAY or SUSTAIN → RELEASE.
- Per-tick level updates (only when no gate event occurs that cycle):
  - ATTACK: if `attack`=0 or `env`+`attack` ≥ `amplitude` → `env`=`amplitude`, go to DECAY. Otherwise `env`+=`attack`.
  - DECAY: if `decay`=0 or `env` ≤ `sus_lvl`+`decay` → `env`=`sus_lvl`, go to SUSTAIN. Otherwise `env`-=`decay`.
  - SUSTAIN: `env`=`sus_lvl`.
  - RELEASE: if `rel`=0 or `env` ≤ `rel` → `env`=0, go to IDLE, pulse `done`. Otherwise `env`-=`rel`.
  - IDLE: `env` is held at 0.
- Arithmetic rules:
  - Sums and compares use WIDTH+1 bits, so the level never wraps.
  - `env` is always between 0 and `amplitude`.
  - If `amplitude` drops below `env`, `env` is clamped to `amplitude` on the next tick in ATTACK, DECAY or SUSTAIN.
- Simultaneous events: a gate event wins over a tick in the same cycle, and no step is applied in that cycle. The next tick steps from the new state.

## Timing
- Reset values: `env`=0, `state`=IDLE, `active`=0, `done`=0, `gate_q`=0.
- Reset asserted mid-envelope forces these values immediately (asynchronously).
- Gate edge to `state` change: the state updates on the first clk edge at which the edge is seen, so `state` is visible 1 cycle after `note_in` changes.
- `tick` to `env`: `env` updates on the same clk edge that samples `tick`=1. Latency is 1 cycle.
- `done` is high for exactly the one cycle after the RELEASE→IDLE edge.
- With step 0, each phase takes exactly 1 tick.

## Configuration
- `ADSR_LEGATO_EN` defined: a rise while in ATTACK, DECAY or SUSTAIN is ignored, and the envelope continues without retriggering. A rise in RELEASE or IDLE still enters ATTACK.
- `ADSR_LEGATO_EN` undefined: every rise retriggers ATTACK from the current `env`.

## Structure
- Shared package `synth_pkg` holds:
  - the state enum `adsr_state_t`, with IDLE, ATTACK, DECAY, SUSTAIN and RELEASE at the codes listed under Interface;
  - the width constant `SYNTH_LVL_W`=31.
- Sub-module `adsr_step_sat`: combinational saturating add/subtract with target compare.
  - Inputs: level, step, target, direction.
  - Outputs: next level and a `reached` flag.
  - It is instantiated once, with its operands muxed by state.

## Test plan
- Reset default: `amplitude`=1000, `attack`=300, `decay`=100, `sustain`=600, `rel`=200, tick every cycle, gate held. Expect `env` 300, 600, 900, 1000 (DECAY), then 900, 800, 700, 600 (SUSTAIN). Drop the gate: `env` 400, 200, 0, with a `done` pulse and IDLE.
- Instant settings: `attack`=0, `decay`=0, `sustain`=max, `rel`=0, gate rise. Expect `env`=`amplitude` after 1 tick and SUSTAIN after the 2nd tick. Drop the gate: `env`=0 after 1 tick.
- Retrigger (macro undefined): gate rise during RELEASE at `env`=400. Expect ATTACK, then 700 on the next tick.
- `ADSR_LEGATO_EN` defined: a rise in SUSTAIN leaves `state`=3 and `env`=600 unchanged. Repeat with the macro undefined: expect ATTACK.
- Clamp and collision: in SUSTAIN, set `amplitude`=500, so `env`→500 on the next tick. Next, raise the gate on the same cycle as a tick: the state changes and `env` is unchanged that cycle.
- Async reset: assert `reset`=0 mid-ATTACK without a clk edge. Expect `env`=0, `state`=0 and `active`=0 immediately.

Source files
------------

// File: rtl/synth_pkg.sv
// -----------------------------------------------------------------------------
// synth_pkg
// Shared types and constants for the synth voice blocks.
//   SYNTH_LVL_W  : default width of level / amplitude / ADSR operands
//   adsr_state_t : envelope phase encoding, also exported as a debug output
//   step_dir_t   : direction selector for the saturating step unit
//   is_held()    : true for the phases that belong to a held key
// -----------------------------------------------------------------------------
package synth_pkg;

    localparam int SYNTH_LVL_W = 31;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } adsr_state_t;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } step_dir_t;

    // Phases in which the key is considered held (gate drop sends them to RELEASE).
    function automatic logic is_held(adsr_state_t s);
        return (s == ATTACK) || (s == DECAY) || (s == SUSTAIN);
    endfunction

endpackage

// File: rtl/adsr_envelope_ctrl_if.sv
// -----------------------------------------------------------------------------
// adsr_envelope_ctrl_if
// Bundle between the parameter/IO registers (master) and the envelope
// sequencer (slave).
//   master drives : tick, note_in, amplitude, attack, decay, sustain, rel
//   slave drives  : env, state, active, done
// Handshake: there is no valid/ready pair. tick is a single-cycle qualifier
// that is consumed on every clk edge where it is 1; the sequencer never
// stalls it. note_in and the settings are level signals sampled every cycle.
// -----------------------------------------------------------------------------
interface adsr_envelope_ctrl_if #(
    parameter int WIDTH = synth_pkg::SYNTH_LVL_W
);
    import synth_pkg::*;

    logic             tick;
    logic             note_in;
    logic [WIDTH-1:0] amplitude;
    logic [WIDTH-1:0] attack;
    logic [WIDTH-1:0] decay;
    logic [WIDTH-1:0] sustain;
    logic [WIDTH-1:0] rel;
    logic [WIDTH-1:0] env;
    adsr_state_t      state;
    logic             active;
    logic             done;

    modport master (
        output tick, note_in, amplitude, attack, decay, sustain, rel,
        input  env, state, active, done
    );

    modport slave (
        input  tick, note_in, amplitude, attack, decay, sustain, rel,
        output env, state, active, done
    );

endinterface

// File: rtl/adsr_step_sat.sv
// -----------------------------------------------------------------------------
// adsr_step_sat
// Combinational saturating step toward a target level.
//   level      : current level
//   step       : increment (DIR_UP) or decrement (DIR_DOWN); 0 = jump to target
//   target     : level at which the phase ends
//   dir        : step direction
//   next_level : level after the step, snapped to target once reached
//   reached    : target met or crossed (or step is 0)
// All sums and compares use WIDTH+1 bits so nothing wraps.
// -----------------------------------------------------------------------------
module adsr_step_sat
    import synth_pkg::*;
#(
    parameter int WIDTH = SYNTH_LVL_W
) (
    input  logic [WIDTH-1:0] level,
    input  logic [WIDTH-1:0] step,
    input  logic [WIDTH-1:0] target,
    input  step_dir_t        dir,
    output logic [WIDTH-1:0] next_level,
    output logic             reached
);

    logic [WIDTH:0] sum_up;
    logic [WIDTH:0] lim_down;

    always_comb begin
        sum_up     = {1'b0, level} + {1'b0, step};
        lim_down   = {1'b0, target} + {1'b0, step};
        next_level = level;
        reached    = 1'b0;
        if (dir == DIR_UP) begin
            reached    = (step == '0) || (sum_up >= {1'b0, target});
            next_level = reached ? target : sum_up[WIDTH-1:0];
        end else begin
            // level <= target + step means one more step would land at or
            // below the target, so finish there instead of undershooting.
            reached    = (step == '0) || ({1'b0, level} <= lim_down);
            next_level = reached ? target : (level - step);
        end
    end

endmodule

// File: rtl/adsr_envelope_ctrl.sv
// -----------------------------------------------------------------------------
// adsr_envelope_ctrl
// Envelope sequencer: turns the key gate and the ADSR settings into a
// time-varying level that scales the oscillator.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low
//   bus   : adsr_envelope_ctrl_if.slave
//           in : tick, note_in, amplitude, attack, decay, sustain, rel
//           out: env (registered level), state (phase), active, done (pulse)
// Build option: define ADSR_LEGATO_EN to ignore key rises while the envelope
// is already in ATTACK/DECAY/SUSTAIN (no retrigger). Default: every rise
// retriggers ATTACK from the current level.
// -----------------------------------------------------------------------------
module adsr_envelope_ctrl
    import synth_pkg::*;
#(
    parameter int WIDTH = SYNTH_LVL_W
) (
    input logic                clk,
    input logic                reset,
    adsr_envelope_ctrl_if.slave bus
);

    logic [WIDTH-1:0] env_q;
    adsr_state_t      state_q;
    logic             active_q;
    logic             done_q;
    logic             gate_q;

    logic [WIDTH-1:0] sus_lvl;
    logic             rise;
    logic             retrig;
    logic             gate_off;

    logic [WIDTH-1:0] st_step;
    logic [WIDTH-1:0] st_target;
    step_dir_t        st_dir;
    logic [WIDTH-1:0] st_next;
    logic             st_reached;

    // Sustain never exceeds the peak; recomputed every cycle so live edits apply.
    always_comb begin
        sus_lvl  = (bus.sustain < bus.amplitude) ? bus.sustain : bus.amplitude;
        rise     = bus.note_in & ~gate_q;
`ifdef ADSR_LEGATO_EN
        retrig   = rise & ~is_held(state_q);
`else
        retrig   = rise;
`endif
        gate_off = ~bus.note_in & is_held(state_q);
    end

    // One step unit shared by all moving phases.
    always_comb begin
        st_step   = '0;
        st_target = '0;
        st_dir    = DIR_DOWN;
        case (state_q)
            ATTACK: begin
                st_step   = bus.attack;
                st_target = bus.amplitude;
                st_dir    = DIR_UP;
            end
            DECAY: begin
                st_step   = bus.decay;
                st_target = sus_lvl;
                st_dir    = DIR_DOWN;
            end
            RELEASE: begin
                st_step   = bus.rel;
                st_target = '0;
                st_dir    = DIR_DOWN;
            end
            default: begin
                st_step   = '0;
                st_target = '0;
                st_dir    = DIR_DOWN;
            end
        endcase
    end

    adsr_step_sat #(
        .WIDTH (WIDTH)
    ) u_step (
        .level      (env_q),
        .step       (st_step),
        .target     (st_target),
        .dir        (st_dir),
        .next_level (st_next),
        .reached    (st_reached)
    );

    // Gate events take priority over tick: a cycle with a gate event only
    // changes phase, the level is stepped from the new phase on later ticks.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            env_q    <= '0;
            state_q  <= IDLE;
            active_q <= 1'b0;
            done_q   <= 1'b0;
            gate_q   <= 1'b0;
        end else begin
            gate_q <= bus.note_in;
            done_q <= 1'b0;
            if (retrig) begin
                state_q  <= ATTACK;
                active_q <= 1'b1;
            end else if (gate_off) begin
                state_q  <= RELEASE;
                active_q <= 1'b1;
            end else if (bus.tick) begin
                case (state_q)
                    ATTACK: begin
                        // Reaching covers a shrunken amplitude: env snaps to it.
                        env_q <= st_next;
                        if (st_reached) state_q <= DECAY;
                    end
                    DECAY: begin
                        env_q <= (st_next > bus.amplitude) ? bus.amplitude : st_next;
                        if (st_reached) state_q <= SUSTAIN;
                    end
                    SUSTAIN: begin
                        env_q <= sus_lvl;
                    end
                    RELEASE: begin
                        env_q <= st_next;
                        if (st_reached) begin
                            state_q  <= IDLE;
                            active_q <= 1'b0;
                            done_q   <= 1'b1;
                        end
                    end
                    default: begin
                        env_q    <= '0;
                        state_q  <= IDLE;
                        active_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.env    = env_q;
    assign bus.state  = state_q;
    assign bus.active = active_q;
    assign bus.done   = done_q;

endmodule

// File: tb/tb_adsr_envelope_ctrl.sv
// -----------------------------------------------------------------------------
// tb_adsr_envelope_ctrl
// Directed scenarios followed by randomized gate/tick/parameter traffic, all
// compared against a phase/level reference model written with plain integer
// arithmetic. Honors ADSR_LEGATO_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_adsr_envelope_ctrl;
    import synth_pkg::*;

    localparam int W = SYNTH_LVL_W;
    localparam longint MAXV = (longint'(1) << W) - 1;
`ifdef ADSR_LEGATO_EN
    localparam bit LEGATO = 1'b1;
`else
    localparam bit LEGATO = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    adsr_envelope_ctrl_if #(.WIDTH(W)) bus ();

    adsr_envelope_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- reference model ----------------
    longint m_env;
    int     m_phase;   // 0 idle, 1 attack, 2 decay, 3 sustain, 4 release
    bit     m_gate;
    bit     m_done;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_env   = 0;
        m_phase = 0;
        m_gate  = 0;
        m_done  = 0;
    endtask

    // Applies the envelope rules to the inputs present before the coming edge.
    task automatic model_edge();
        longint amp, sus, a, d, r;
        bit rise, held;
        amp  = longint'(bus.amplitude);
        a    = longint'(bus.attack);
        d    = longint'(bus.decay);
        r    = longint'(bus.rel);
        sus  = (longint'(bus.sustain) < amp) ? longint'(bus.sustain) : amp;
        rise = bus.note_in && !m_gate;
        held = (m_phase >= 1) && (m_phase <= 3);
        m_done = 0;
        if (rise && !(LEGATO && held)) begin
            m_phase = 1;
        end else if (!bus.note_in && held) begin
            m_phase = 4;
        end else if (bus.tick) begin
            if (m_phase == 1) begin
                if (a == 0 || m_env + a >= amp) begin
                    m_env = amp;  m_phase = 2;
                end else m_env = m_env + a;
            end else if (m_phase == 2) begin
                if (d == 0 || m_env <= sus + d) begin
                    m_env = sus;  m_phase = 3;
                end else m_env = m_env - d;
                if (m_env > amp) m_env = amp;
            end else if (m_phase == 3) begin
                m_env = sus;
            end else if (m_phase == 4) begin
                if (r == 0 || m_env <= r) begin
                    m_env = 0;  m_phase = 0;  m_done = 1;
                end else m_env = m_env - r;
            end else begin
                m_env = 0;
            end
        end
        m_gate = bus.note_in;
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_params(input longint amp, input longint att, input longint dec,
                              input longint sus, input longint rl);
        bus.amplitude = amp[W-1:0];
        bus.attack    = att[W-1:0];
        bus.decay     = dec[W-1:0];
        bus.sustain   = sus[W-1:0];
        bus.rel       = rl[W-1:0];
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_env"},    64'(bus.env),    64'(m_env));
        chk({tag, "_state"},  64'(bus.state),  64'(m_phase));
        chk({tag, "_active"}, 64'(bus.active), 64'(m_phase != 0));
        chk({tag, "_done"},   64'(bus.done),   64'(m_done));
    endtask

    // One clock: model consumes the same inputs the DUT samples, then compare.
    task automatic cycle(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) cycle(tag);
    endtask

    // ---------------- stimulus ----------------
    int exp_dflt[8] = '{300, 600, 900, 1000, 900, 800, 700, 600};
    int exp_rel[3]  = '{400, 200, 0};

    initial begin
        reset       = 1'b0;
        bus.tick    = 1'b0;
        bus.note_in = 1'b0;
        set_params(1000, 300, 100, 600, 200);
        model_reset();
        #12;
        chk("rst_env",    64'(bus.env),    64'd0);
        chk("rst_state",  64'(bus.state),  64'd0);
        chk("rst_active", 64'(bus.active), 64'd0);
        chk("rst_done",   64'(bus.done),   64'd0);
        reset = 1'b1;

        // Default ADSR walk.
        bus.tick    = 1'b1;
        bus.note_in = 1'b1;
        cycle("dflt_rise");
        chk("dflt_rise_st", 64'(bus.state), 64'd1);
        for (int i = 0; i < 8; i++) begin
            cycle("dflt");
            chk("dflt_lvl", 64'(bus.env), 64'(exp_dflt[i]));
            if (i == 3) chk("dflt_decay_st", 64'(bus.state), 64'd2);
        end
        chk("dflt_sus_st", 64'(bus.state), 64'd3);
        bus.note_in = 1'b0;
        cycle("dflt_drop");
        chk("dflt_rel_st", 64'(bus.state), 64'd4);
        for (int i = 0; i < 3; i++) begin
            cycle("dflt_rel");
            chk("dflt_rel_lvl", 64'(bus.env), 64'(exp_rel[i]));
        end
        chk("dflt_done", 64'(bus.done), 64'd1);
        chk("dflt_idle", 64'(bus.state), 64'd0);
        cycle("dflt_after");
        chk("dflt_done_clr", 64'(bus.done), 64'd0);

        // Retrigger from RELEASE at 400.
        bus.note_in = 1'b1;
        run(9, "rt_up");
        bus.note_in = 1'b0;
        run(2, "rt_rel");
        chk("rt_at400", 64'(bus.env), 64'd400);
        bus.note_in = 1'b1;
        cycle("rt_rise");
        chk("rt_state", 64'(bus.state), 64'd1);
        chk("rt_keep",  64'(bus.env),   64'd400);
        cycle("rt_step");
        chk("rt_700",   64'(bus.env),   64'd700);

        // Clamp on amplitude drop, then gate events colliding with ticks.
        run(10, "cl_up");
        chk("cl_sus", 64'(bus.state), 64'd3);
        set_params(500, 300, 100, 600, 200);
        cycle("cl_clamp");
        chk("cl_500", 64'(bus.env), 64'd500);
        bus.note_in = 1'b0;
        cycle("col_drop");
        chk("col_drop_st",  64'(bus.state), 64'd4);
        chk("col_drop_env", 64'(bus.env),   64'd500);
        bus.note_in = 1'b1;
        cycle("col_rise");
        chk("col_rise_st",  64'(bus.state), 64'd1);
        chk("col_rise_env", 64'(bus.env),   64'd500);

        // Instantaneous settings.
        set_params(1000, 0, 0, MAXV, 0);
        bus.note_in = 1'b0;
        run(2, "inst_clear");
        chk("inst_idle", 64'(bus.state), 64'd0);
        bus.note_in = 1'b1;
        cycle("inst_rise");
        cycle("inst_att");
        chk("inst_amp", 64'(bus.env), 64'd1000);
        cycle("inst_dec");
        chk("inst_sus", 64'(bus.state), 64'd3);
        bus.note_in = 1'b0;
        cycle("inst_drop");
        cycle("inst_rel");
        chk("inst_zero", 64'(bus.env), 64'd0);
        chk("inst_done", 64'(bus.done), 64'd1);

        // Asynchronous reset mid-ATTACK.
        set_params(1000, 300, 100, 600, 200);
        bus.note_in = 1'b1;
        run(2, "ar_att");
        chk("ar_pre", 64'(bus.env), 64'd300);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_env",    64'(bus.env),    64'd0);
        chk("ar_state",  64'(bus.state),  64'd0);
        chk("ar_active", 64'(bus.active), 64'd0);
        model_reset();
        @(negedge clk);
        bus.note_in = 1'b0;
        reset = 1'b1;

        // Randomized traffic.
        begin
            int hold;
            hold = 0;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 59) == 0) begin
                    if ($urandom_range(0, 3) == 0)
                        set_params(longint'($urandom) & MAXV, longint'($urandom) & MAXV,
                                   longint'($urandom) & MAXV, longint'($urandom) & MAXV,
                                   longint'($urandom) & MAXV);
                    else
                        set_params($urandom_range(0, 2000), $urandom_range(0, 400),
                                   $urandom_range(0, 400), $urandom_range(0, 2500),
                                   $urandom_range(0, 400));
                end
                if (hold == 0) begin
                    bus.note_in = ~bus.note_in;
                    hold = $urandom_range(1, 40);
                end else begin
                    hold--;
                end
                bus.tick = ($urandom_range(0, 3) != 0);
                cycle("rnd");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
